fft_input_framer: RTL
=====================

Name: fft_input_framer

Overview:
- Streaming front end of the 1024-point FFT core (dft_top).
- Accepts real 16-bit audio samples one at a time via a valid/ready handshake and packs them into 1024-sample frames in a ping-pong buffer.
- For each full frame it drives the dft_top input protocol: a one-cycle next pulse, then 512 beats carrying 2 complex words per beat (X0..X3), with zero imaginary parts.

Parameters:
- N, 1024: points per frame; power of two, at least 4.
- W, 16: sample and word width.
- GAP, 512: minimum number of cycles between successive next pulses, as required by dft_top.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_valid  in  1  input sample valid.
- s_data  in  W  input sample, two's complement.
- s_ready  out  1  framer can accept a sample; a sample transfers when s_valid and s_ready are both high.
- start_en  in  1  when low, no new frame is started; a frame already in progress always completes.
- next  out  1  one-cycle start pulse to dft_top.
- X0  out  W  real part of sample 2j.
- X1  out  W  imaginary part of sample 2j; always 0.
- X2  out  W  real part of sample 2j+1.
- X3  out  W  imaginary part of sample 2j+1; always 0.
- busy  out  1  high from the next pulse through the last beat.
- frames_out  out  16  count of frames issued; wraps.

Behaviour:
- Reset (reset=0): next=0, X0..X3=0, busy=0, frames_out=0, both banks empty, write bank=0, write pointer=0. s_ready=1 from the first cycle after reset deasserts. Reset asserted mid-stream aborts the frame immediately; no partial beats are emitted after it.
- Storage: 2 banks, each N/2 entries of 2W bits. Even samples go in the low half of an entry, odd samples in the high half. A pair is written when its odd sample is accepted.
- Write side:
  - The write pointer counts 0..N-1 in the current write bank.
  - On acceptance of sample N-1: set full[wbank], toggle wbank, reset the pointer.
  - s_ready = !full[wbank].
- Read FSM states: IDLE, STREAM.
  - IDLE to STREAM: when full[rbank], start_en=1, and the gap counter is at least GAP-1, assert next for exactly one cycle (cycle c) and clear the gap counter.
  - Beat j (0..N/2-1) is presented in cycle c+1+j:
    - X0 = sample 2j, X2 = sample 2j+1.
    - X1 = X3 = 0.
    - Outputs are registered and reach dft_top unchanged, with no sign or scale change.
  - In the cycle after beat N/2-1: clear full[rbank], toggle rbank, return to IDLE, drive X0..X3=0, and increment frames_out.
  - Back-to-back: if the other bank is full and start_en=1, next for the following frame is asserted in the same cycle as beat N/2-1. The two next pulses are therefore exactly GAP=512 cycles apart.
- Gap counter: saturates at GAP-1; it is GAP-1 after reset, so the first frame is not delayed by it.
- Latency: next is asserted in the cycle after the sample N-1 handshake, when the bank is free to read, start_en=1 and the gap is satisfied.
- X0..X3 are 0 whenever no beat is being presented.
- Simultaneous events:
  - Bank release and completion of a write into the other bank in the same cycle: both take effect, with no lost flag updates.
  - Release of bank b in the same cycle the writer is stalled on b: s_ready rises the next cycle.
- Overflow is impossible; input is backpressured via s_ready and no samples are dropped.
- The input sample rate is otherwise unconstrained (any s_valid pattern is legal).

Decomposition:
- Shared package fft_pkg holds:
  - the constants FFT_N=1024, FFT_W=16, FFT_GAP=512;
  - BEATS = FFT_N/2;
  - the beat typedef, a struct {re0, im0, re1, im1} of W bits each.
- One natural sub-module, framer_pingpong_ram: a 2-bank simple dual-port RAM of N/2 x 2W per bank with 1-cycle registered read. The read FSM issues each address one cycle ahead to hide the read latency.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release. During reset all outputs are 0; s_ready=1 on the first cycle after release; next stays 0 with no input.
- Single frame: feed s_data=k for k=0..1023, one per cycle, with start_en=1.
  - next pulses once, in the cycle after the accept of sample 1023.
  - Beat j gives X0=2j, X1=0, X2=2j+1, X3=0 for j=0..511; X0..X3 are 0 afterwards; frames_out=1.
- Backpressure and back-to-back: with start_en=0, offer 2049 samples.
  - s_ready falls after 2048 accepts; sample 2048 is held.
  - Raise start_en: two next pulses exactly 512 cycles apart, the second coincident with beat 511 of frame 1.
  - Sample 2048 is accepted the cycle after bank 0 is released.
- Sign and sparse input: feed 0x8000, 0x7FFF, 0xFFFF repeating, with s_valid toggling randomly at 30% duty.
  - The beat stream reproduces the samples bit-exact in order.
  - The gap between frames is at least 512 cycles.
- Reset mid-stream: assert reset at beat 100 of a frame.
  - Outputs are 0 within the same cycle (asynchronous); frames_out=0.
  - After release, a new 1024-sample input starts a frame whose beat 0 carries sample 0 of the new data.
- start_en drop mid-frame: lower start_en at beat 10. All 512 beats still complete, and no further next pulses occur until start_en=1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and types for the dft_top streaming front end.
package fft_pkg;

  localparam int FFT_N   = 1024;
  localparam int FFT_W   = 16;
  localparam int FFT_GAP = 512;
  localparam int BEATS   = FFT_N / 2;

  typedef struct packed {
    logic [FFT_W-1:0] re0;
    logic [FFT_W-1:0] im0;
    logic [FFT_W-1:0] re1;
    logic [FFT_W-1:0] im1;
  } beat_t;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

endpackage

// File: rtl/framer_pingpong_ram.sv
// Two-bank simple dual-port RAM, one pair of samples per entry, registered read.
module framer_pingpong_ram #(
  parameter int DEPTH = 512,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          wbank_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          rbank_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2*DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[{wbank_i, waddr_i}] <= wdata_i;
    end
    rdata_q <= mem_q[{rbank_i, raddr_i}];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_input_framer.sv
// Packs a real sample stream into N-sample ping-pong frames and replays each
// frame to dft_top as N/2 beats of two complex words with zero imaginary parts.
module fft_input_framer
  import fft_pkg::*;
#(
  parameter int N   = FFT_N,
  parameter int W   = FFT_W,
  parameter int GAP = FFT_GAP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  input  logic [W-1:0]  s_data,
  output logic          s_ready,
  input  logic          start_en,
  output logic          next,
  output logic [W-1:0]  X0,
  output logic [W-1:0]  X1,
  output logic [W-1:0]  X2,
  output logic [W-1:0]  X3,
  output logic          busy,
  output logic [15:0]   frames_out
);

  localparam int NB = N / 2;
  localparam int AW = $clog2(N);
  localparam int BW = $clog2(NB);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(N - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(NB - 1);
  localparam logic [BW-1:0] BEAT_TURN = BW'(NB - 2);
  localparam logic [GW-1:0] GAP_SAT   = GW'(GAP - 1);

  // write side
  logic          wbank_q, wbank_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [W-1:0]  low_q, low_d;
  logic [1:0]    full_q, full_d;
  logic          s_ready_q;
  logic          accept, pair_we, frame_done;

  // read side
  rd_state_t     state_q, state_d;
  logic          rbank_q, rbank_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   frames_q, frames_d;
  beat_t         beat_q, beat_d;
  logic          in_stream, last_beat, nbank, launch, release_bank;
  logic          rd_bank;
  logic [BW-1:0] rd_addr;
  logic [2*W-1:0] rd_data;

  framer_pingpong_ram #(
    .DEPTH (NB),
    .DW    (2 * W),
    .AW    (BW)
  ) u_ram (
    .clk     (clk),
    .we_i    (pair_we),
    .wbank_i (wbank_q),
    .waddr_i (wptr_q[AW-1:1]),
    .wdata_i ({s_data, low_q}),
    .rbank_i (rd_bank),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    accept     = s_valid && s_ready_q;
    pair_we    = accept && wptr_q[0];
    frame_done = accept && (wptr_q == PTR_LAST);
    wptr_d     = wptr_q;
    wbank_d    = wbank_q;
    low_d      = low_q;
    if (accept) begin
      if (!wptr_q[0]) begin
        low_d = s_data;
      end
      wptr_d = wptr_q + AW'(1);
      if (frame_done) begin
        wbank_d = ~wbank_q;
      end
    end
  end

  // Next-frame decision is made either from IDLE or on the final beat, so the
  // bank to launch is the other one while streaming.
  always_comb begin
    in_stream = (state_q == RD_STREAM);
    last_beat = in_stream && (cnt_q == BEAT_LAST);
    nbank     = in_stream ? ~rbank_q : rbank_q;
    launch    = (!in_stream || last_beat) && full_q[nbank] && start_en && (gap_q == GAP_SAT);
    rd_bank   = (!in_stream || (cnt_q >= BEAT_TURN)) ? nbank : rbank_q;
    if (!in_stream || last_beat) begin
      rd_addr = launch ? BW'(1) : '0;
    end else begin
      rd_addr = cnt_q + BW'(2);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rbank_d      = rbank_q;
    frames_d     = frames_q;
    release_bank = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (launch) begin
          state_d = RD_STREAM;
          cnt_d   = '0;
        end
      end
      RD_STREAM: begin
        cnt_d = cnt_q + BW'(1);
        if (last_beat) begin
          release_bank = 1'b1;
          rbank_d      = ~rbank_q;
          frames_d     = frames_q + 16'd1;
          state_d      = launch ? RD_STREAM : RD_IDLE;
          cnt_d        = '0;
        end
      end
      default: state_d = RD_IDLE;
    endcase

    gap_d = launch ? '0 : ((gap_q == GAP_SAT) ? gap_q : gap_q + GW'(1));

    // Release and set always target different banks, so both land.
    full_d = full_q;
    if (release_bank) begin
      full_d[rbank_q] = 1'b0;
    end
    if (frame_done) begin
      full_d[wbank_q] = 1'b1;
    end

    beat_d = '0;
    if (state_d == RD_STREAM) begin
      beat_d.re0 = rd_data[W-1:0];
      beat_d.re1 = rd_data[2*W-1:W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbank_q   <= 1'b0;
      wptr_q    <= '0;
      low_q     <= '0;
      full_q    <= '0;
      s_ready_q <= 1'b0;
      state_q   <= RD_IDLE;
      rbank_q   <= 1'b0;
      cnt_q     <= '0;
      gap_q     <= GAP_SAT;
      frames_q  <= '0;
      beat_q    <= '0;
    end else begin
      wbank_q   <= wbank_d;
      wptr_q    <= wptr_d;
      low_q     <= low_d;
      full_q    <= full_d;
      s_ready_q <= ~full_d[wbank_d];
      state_q   <= state_d;
      rbank_q   <= rbank_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      frames_q  <= frames_d;
      beat_q    <= beat_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign next       = launch;
  assign busy       = launch || in_stream;
  assign X0         = beat_q.re0;
  assign X1         = beat_q.im0;
  assign X2         = beat_q.re1;
  assign X3         = beat_q.im1;
  assign frames_out = frames_q;

endmodule
